// File: rtl/counter_event_capture.sv
// Compare-match / wrap event detector with a small FWFT snapshot FIFO.
// Optional CAPTURE_DROP_CNT_EN adds a saturating dropped-capture counter (drop_cnt).
module counter_event_capture #(
    parameter int CNT_W = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    input  logic             cnt_en_in,
    input  logic [CNT_W-1:0] cmp_val,
    input  logic             cmp_load,
    input  logic             trig,
    output logic [CNT_W-1:0] cap_data,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic             match,
    output logic             wrap,
    output logic             fifo_full
`ifdef CAPTURE_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    logic [CNT_W-1:0] cmp_reg_q, cmp_reg_d;
    logic             eq_d_q, eq_d_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    logic eq;
    logic req;
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        eq    = (count_in == cmp_reg_q);
        req   = trig | (eq & ~eq_d_q);
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop   = ~empty & cap_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push  = req & (~full | pop);
        drop  = req & full & ~pop;

        cmp_reg_d = cmp_load ? cmp_val : cmp_reg_q;
        eq_d_d    = eq;
        match_d   = eq & ~eq_d_q;
        wrap_d    = cnt_en_in & (count_in == {CNT_W{1'b1}});

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = count_in;
        end
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_reg_q <= {CNT_W{1'b1}};
            eq_d_q    <= 1'b0;
            match_q   <= 1'b0;
            wrap_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cmp_reg_q <= cmp_reg_d;
            eq_d_q    <= eq_d_d;
            match_q   <= match_d;
            wrap_q    <= wrap_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef CAPTURE_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

    assign cap_data  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign cap_valid = ~empty;
    assign fifo_full = full;
    assign match     = match_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_counter_event_capture.sv
// Directed bench for counter_event_capture: compare, wrap, FIFO ordering/full/drop, reset flush.
module tb_counter_event_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] count_in;
    logic        cnt_en_in;
    logic [15:0] cmp_val;
    logic        cmp_load;
    logic        trig;
    logic [15:0] cap_data;
    logic        cap_valid;
    logic        cap_ready;
    logic        match;
    logic        wrap;
    logic        fifo_full;
`ifdef CAPTURE_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    counter_event_capture dut (
        .clk       (clk),
        .reset     (reset),
        .count_in  (count_in),
        .cnt_en_in (cnt_en_in),
        .cmp_val   (cmp_val),
        .cmp_load  (cmp_load),
        .trig      (trig),
        .cap_data  (cap_data),
        .cap_valid (cap_valid),
        .cap_ready (cap_ready),
        .match     (match),
        .wrap      (wrap),
        .fifo_full (fifo_full)
`ifdef CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; count_in = 16'd0; cnt_en_in = 1'b0; cmp_val = 16'd0;
        cmp_load = 1'b0; trig = 1'b0; cap_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        total++; if (cap_valid !== 1'b0) begin $display("FAIL reset_cap_valid got=%0h exp=0", cap_valid); bad++; end
        total++; if (fifo_full !== 1'b0) begin $display("FAIL reset_fifo_full got=%0h exp=0", fifo_full); bad++; end
        total++; if (cap_data !== 16'd0) begin $display("FAIL reset_cap_data got=%0h exp=0", cap_data); bad++; end
        total++; if (match !== 1'b0) begin $display("FAIL reset_match got=%0h exp=0", match); bad++; end
        total++; if (wrap !== 1'b0) begin $display("FAIL reset_wrap got=%0h exp=0", wrap); bad++; end
`ifdef CAPTURE_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd0) begin $display("FAIL reset_drop_cnt got=%0h exp=0", drop_cnt); bad++; end
`endif
    endtask

    task automatic test_no_match();
        cnt_en_in = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            count_in = 16'(i);
            tick();
            total++; if ({match, wrap, cap_valid, fifo_full} !== 4'b0000)
                begin $display("FAIL nomatch_outputs i=%0d got=%b exp=0000", i, {match, wrap, cap_valid, fifo_full}); bad++; end
        end
    endtask

    task automatic test_match();
        cmp_val = 16'd10; cmp_load = 1'b1; count_in = 16'd21;
        tick();
        cmp_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            count_in = 16'(i);
            tick();
            total++; if (match !== 1'b0) begin $display("FAIL match_early i=%0d got=%0h exp=0", i, match); bad++; end
        end
        count_in = 16'd10;
        tick();
        total++; if (match !== 1'b1) begin $display("FAIL match_pulse got=%0h exp=1", match); bad++; end
        total++; if (cap_valid !== 1'b1) begin $display("FAIL match_cap_valid got=%0h exp=1", cap_valid); bad++; end
        total++; if (cap_data !== 16'd10) begin $display("FAIL match_cap_data got=%0h exp=a", cap_data); bad++; end
        // hold 4 more cycles; second of them reloads the same compare value
        for (int i = 0; i < 4; i++) begin
            cmp_load = (i == 1);
            tick();
            total++; if (match !== 1'b0) begin $display("FAIL match_hold i=%0d got=%0h exp=0", i, match); bad++; end
        end
        cmp_load = 1'b0;
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        total++; if (cap_valid !== 1'b0) begin $display("FAIL match_single_snapshot got=%0h exp=0", cap_valid); bad++; end
        count_in = 16'd11;
        tick();
        total++; if (match !== 1'b0) begin $display("FAIL match_after got=%0h exp=0", match); bad++; end
    endtask

    task automatic test_wrap();
        count_in = 16'hFFFF; cnt_en_in = 1'b1;
        tick();
        total++; if (wrap !== 1'b1) begin $display("FAIL wrap_pulse got=%0h exp=1", wrap); bad++; end
        count_in = 16'h0000;
        tick();
        total++; if (wrap !== 1'b0) begin $display("FAIL wrap_clear got=%0h exp=0", wrap); bad++; end
        count_in = 16'hFFFF; cnt_en_in = 1'b0;
        tick();
        total++; if (wrap !== 1'b0) begin $display("FAIL wrap_disabled got=%0h exp=0", wrap); bad++; end
        tick();
        total++; if (wrap !== 1'b0) begin $display("FAIL wrap_disabled2 got=%0h exp=0", wrap); bad++; end
        count_in = 16'd50;
        tick();
    endtask

    task automatic test_full_and_drop();
        logic [15:0] exp_q [4];
        exp_q[0] = 16'd101; exp_q[1] = 16'd102; exp_q[2] = 16'd103; exp_q[3] = 16'd200;
        cap_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            count_in = 16'(99 + k); trig = 1'b1;
            tick();
            total++; if (fifo_full !== (k >= 4)) begin $display("FAIL full_flag k=%0d got=%0h exp=%0h", k, fifo_full, (k >= 4)); bad++; end
            total++; if (cap_data !== 16'd100) begin $display("FAIL full_head k=%0d got=%0d exp=100", k, cap_data); bad++; end
        end
        trig = 1'b0;
`ifdef CAPTURE_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd2) begin $display("FAIL drop_cnt got=%0d exp=2", drop_cnt); bad++; end
`endif
        // full FIFO: push and pop in the same cycle
        count_in = 16'd200; trig = 1'b1; cap_ready = 1'b1;
        tick();
        trig = 1'b0; cap_ready = 1'b0;
        total++; if (fifo_full !== 1'b1) begin $display("FAIL full_pushpop_full got=%0h exp=1", fifo_full); bad++; end
        total++; if (cap_data !== 16'd101) begin $display("FAIL full_pushpop_head got=%0d exp=101", cap_data); bad++; end
`ifdef CAPTURE_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd2) begin $display("FAIL full_pushpop_drop got=%0d exp=2", drop_cnt); bad++; end
`endif
        tick(); tick();
        total++; if (cap_data !== 16'd101) begin $display("FAIL hold_no_ready got=%0d exp=101", cap_data); bad++; end
        for (int i = 0; i < 4; i++) begin
            total++; if (cap_valid !== 1'b1 || cap_data !== exp_q[i])
                begin $display("FAIL drain_order i=%0d got=%0d/%0h exp=%0d/1", i, cap_data, cap_valid, exp_q[i]); bad++; end
            cap_ready = 1'b1;
            tick();
            cap_ready = 1'b0;
            total++; if (fifo_full !== 1'b0) begin $display("FAIL drain_full i=%0d got=%0h exp=0", i, fifo_full); bad++; end
        end
        total++; if (cap_valid !== 1'b0) begin $display("FAIL drain_empty got=%0h exp=0", cap_valid); bad++; end
    endtask

    task automatic test_edge_cases();
        // pop while empty is ignored
        cap_ready = 1'b1;
        tick(); tick();
        cap_ready = 1'b0;
        total++; if (cap_valid !== 1'b0) begin $display("FAIL empty_pop got=%0h exp=0", cap_valid); bad++; end
        count_in = 16'd77; trig = 1'b1;
        tick();
        trig = 1'b0;
        total++; if (cap_valid !== 1'b1 || cap_data !== 16'd77)
            begin $display("FAIL push_latency got=%0d/%0h exp=77/1", cap_data, cap_valid); bad++; end
        // occupancy 1: push and pop together
        count_in = 16'd88; trig = 1'b1; cap_ready = 1'b1;
        tick();
        trig = 1'b0; cap_ready = 1'b0;
        total++; if (cap_valid !== 1'b1 || cap_data !== 16'd88)
            begin $display("FAIL occ1_pushpop got=%0d/%0h exp=88/1", cap_data, cap_valid); bad++; end
        cap_ready = 1'b1;
        tick();
        cap_ready = 1'b0;
        total++; if (cap_valid !== 1'b0) begin $display("FAIL occ1_drained got=%0h exp=0", cap_valid); bad++; end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            count_in = 16'(300 + i); trig = 1'b1;
            tick();
        end
        trig = 1'b0;
        total++; if (cap_valid !== 1'b1 || cap_data !== 16'd300)
            begin $display("FAIL pre_reset got=%0d/%0h exp=300/1", cap_data, cap_valid); bad++; end
        count_in = 16'd0; reset = 1'b1; cap_ready = 1'b1;
        tick();
        reset = 1'b0; cap_ready = 1'b0;
        total++; if (cap_valid !== 1'b0) begin $display("FAIL midreset_valid got=%0h exp=0", cap_valid); bad++; end
        total++; if (fifo_full !== 1'b0) begin $display("FAIL midreset_full got=%0h exp=0", fifo_full); bad++; end
        total++; if (cap_data !== 16'd0) begin $display("FAIL midreset_data got=%0h exp=0", cap_data); bad++; end
`ifdef CAPTURE_DROP_CNT_EN
        total++; if (drop_cnt !== 8'd0) begin $display("FAIL midreset_drop got=%0d exp=0", drop_cnt); bad++; end
`endif
        // compare register must be back to all ones
        count_in = 16'hFFFF; cnt_en_in = 1'b0;
        tick();
        total++; if (match !== 1'b1) begin $display("FAIL midreset_cmp_match got=%0h exp=1", match); bad++; end
        total++; if (cap_valid !== 1'b1 || cap_data !== 16'hFFFF)
            begin $display("FAIL midreset_cmp_snap got=%0h/%0h exp=ffff/1", cap_data, cap_valid); bad++; end
    endtask

    initial begin
        test_reset();
        test_no_match();
        test_match();
        test_wrap();
        test_full_and_drop();
        test_edge_cases();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
